apb_master_lite2: RTL and testbench
===================================

Name: apb_master_lite2

Overview:
- Single-outstanding APB initiator. Converts a simple valid/ready command interface into APB setup/access transfers toward peripheral slaves such as the GPIO.
- Sits between an on-chip control source (test sequencer, boot/config engine) and the APB peripheral bus.
- Returns read data and an error/timeout status as a one-cycle response pulse.
- Supports Rev2 slaves (tie pready2 high) and wait-state slaves (pready2/pslverr2).

Parameters:
ADDR_WIDTH2, 6, width of paddr2/cmd_addr2
DATA_WIDTH2, 32, width of pwdata2/prdata2/cmd_wdata2/rsp_rdata2
TIMEOUT_CYCLES2, 16, max wait-state cycles in ACCESS before abort; 0 = no timeout (counter width = clog2(TIMEOUT_CYCLES2+1), min 1)

Ports:
pclk2  input  1  APB clock, all logic rising-edge
p_reset2  input  1  asynchronous active-high reset
cmd_valid2  input  1  command request
cmd_ready2  output  1  command accepted when both high
cmd_write2  input  1  1 = write, 0 = read
cmd_addr2  input  ADDR_WIDTH2  target address
cmd_wdata2  input  DATA_WIDTH2  write data
rsp_valid2  output  1  one-cycle response pulse
rsp_rdata2  output  DATA_WIDTH2  read data (0 for writes/timeouts)
rsp_err2  output  1  pslverr2 or timeout
psel2  output  1  APB select
penable2  output  1  APB enable
pwrite2  output  1  APB direction
paddr2  output  ADDR_WIDTH2  APB address
pwdata2  output  DATA_WIDTH2  APB write data
prdata2  input  DATA_WIDTH2  APB read data
pready2  input  1  slave ready (tie 1 for Rev2 slaves)
pslverr2  input  1  slave error (tie 0 if unused)

Behaviour:
- Reset (async, immediate): state IDLE; psel2, penable2, pwrite2, paddr2, pwdata2, rsp_valid2, rsp_rdata2, rsp_err2, wait counter = 0; cmd_ready2 = 1.
- FSM states IDLE, SETUP, ACCESS.
- cmd_ready2 is combinational: 1 only in IDLE.
- IDLE:
  - Accept on the edge where cmd_valid2 & cmd_ready2.
  - Register cmd_write2/cmd_addr2/cmd_wdata2 into pwrite2/paddr2/pwdata2; go to SETUP.
- SETUP: psel2 = 1, penable2 = 0; unconditionally go to ACCESS next edge.
- ACCESS: psel2 = 1, penable2 = 1.
  - pready2 = 1 at the edge: complete.
    - Next cycle rsp_valid2 = 1.
    - rsp_rdata2 = prdata2 sampled at that edge for reads, 0 for writes.
    - rsp_err2 = pslverr2 sampled at that edge.
    - Go to IDLE.
  - pready2 = 0: stay in ACCESS; wait counter increments.
  - Timeout (TIMEOUT_CYCLES2 > 0): counter reaching TIMEOUT_CYCLES2 with pready2 still 0 aborts.
    - rsp_valid2 = 1, rsp_err2 = 1, rsp_rdata2 = 0 next cycle.
    - psel2/penable2 drop; go to IDLE.
  - Counter clears on leaving ACCESS.
- pready2 and pslverr2 are ignored outside ACCESS.
- psel2 and penable2 are registered (glitch-free).
- paddr2/pwrite2/pwdata2 stay stable from SETUP through completion. They hold their last value in IDLE and change only on accept.
- rsp_valid2 is high exactly one cycle per accepted command; no backpressure on the response.
  - rsp_rdata2/rsp_err2 hold until the next response.
  - rsp_valid2 returns to 0 after the pulse.
- Latency, zero wait states: accept at edge N; SETUP cycle N+1; ACCESS cycle N+2; completion at edge ending ACCESS; rsp_valid2 in cycle N+3.
  - cmd_ready2 is high again in the rsp_valid2 cycle, so the minimum period is 3 cycles per transfer.
  - psel2 deasserts for at least one cycle between transfers.
- Wait states: each pready2 = 0 cycle in ACCESS adds one cycle to latency.
- cmd_valid2 held high continuously: a new command is accepted in the rsp_valid2 cycle of the previous one.
- Reset mid-SETUP/ACCESS: bus returns to idle immediately; no response is emitted for the aborted command.
- Read data is sampled only at completion. Slaves that register read data in the setup phase, with psel2 & ~penable2, are therefore supported.

Test Plan:
- Zero-wait write: cmd_addr2 = 0x04, cmd_wdata2 = 0x0000_00FF, pready2 = 1 -> psel2 high 2 cycles, penable2 high in 2nd, paddr2 = 0x04, pwdata2 = 0xFF; rsp_valid2 pulse in cycle N+3, rsp_err2 = 0, rsp_rdata2 = 0.
- Zero-wait read: cmd_addr2 = 0x08, slave drives prdata2 = 0x0000_A5A5 -> rsp_rdata2 = 0x0000_A5A5, rsp_err2 = 0, pwrite2 = 0 throughout.
- Wait states: pready2 low for 3 ACCESS cycles, then high with prdata2 = 0x1234 -> ACCESS lasts 4 cycles, paddr2 stable, rsp_valid2 at N+6, rsp_rdata2 = 0x1234.
- Slave error: pready2 = 1, pslverr2 = 1 on a write -> rsp_valid2 with rsp_err2 = 1; the next clean read gives rsp_err2 = 0.
- Timeout: TIMEOUT_CYCLES2 = 4, pready2 held 0 -> abort after 4 wait cycles; rsp_err2 = 1, rsp_rdata2 = 0, psel2 = 0, cmd_ready2 = 1.
- Reset/back-to-back:
  - Assert p_reset2 during ACCESS -> all outputs 0 same cycle, cmd_ready2 = 1, no rsp_valid2.
  - Then 3 commands with cmd_valid2 held -> accepts every 3rd cycle, 3 responses in order.

Source files
------------

// File: rtl/apb_master_lite2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : apb_master_lite2
//  Brief    : Single-outstanding APB initiator. Turns a valid/ready command
//             into an APB SETUP/ACCESS transfer and returns read data plus
//             error/timeout status as a one-cycle response pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_lite2 #(
  parameter int ADDR_WIDTH2     = 6,
  parameter int DATA_WIDTH2     = 32,
  parameter int TIMEOUT_CYCLES2 = 16
) (
  input  logic                   pclk2,
  input  logic                   p_reset2,
  // command side
  input  logic                   cmd_valid2,
  output logic                   cmd_ready2,
  input  logic                   cmd_write2,
  input  logic [ADDR_WIDTH2-1:0] cmd_addr2,
  input  logic [DATA_WIDTH2-1:0] cmd_wdata2,
  // response side
  output logic                   rsp_valid2,
  output logic [DATA_WIDTH2-1:0] rsp_rdata2,
  output logic                   rsp_err2,
  // APB side
  output logic                   psel2,
  output logic                   penable2,
  output logic                   pwrite2,
  output logic [ADDR_WIDTH2-1:0] paddr2,
  output logic [DATA_WIDTH2-1:0] pwdata2,
  input  logic [DATA_WIDTH2-1:0] prdata2,
  input  logic                   pready2,
  input  logic                   pslverr2
);

  // Wait counter wide enough to hold TIMEOUT_CYCLES2; at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES2 > 0) ? $clog2(TIMEOUT_CYCLES2 + 1) : 1;
  // Abort fires on the wait cycle that would bring the count to the limit.
  localparam int                 TO_LAST_I = (TIMEOUT_CYCLES2 > 0) ? TIMEOUT_CYCLES2 - 1 : 0;
  localparam logic [CNT_W-1:0]   TO_LAST   = TO_LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH2-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH2-1:0] pwdata_q, pwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH2-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   timeout_hit;

  // Timeout only exists when a non-zero limit is configured.
  assign timeout_hit = (TIMEOUT_CYCLES2 != 0) && (cnt_q == TO_LAST);

  // Next-state, transfer and response logic; bus strobes follow the next state
  // so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid2) begin
          pwrite_d = cmd_write2;
          paddr_d  = cmd_addr2;
          pwdata_d = cmd_wdata2;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready2) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata2;
          rsp_err_d   = pslverr2;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge pclk2 or posedge p_reset2) begin
    if (p_reset2) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready2 = (state_q == S_IDLE);
  assign psel2      = psel_q;
  assign penable2   = penable_q;
  assign pwrite2    = pwrite_q;
  assign paddr2     = paddr_q;
  assign pwdata2    = pwdata_q;
  assign rsp_valid2 = rsp_valid_q;
  assign rsp_rdata2 = rsp_rdata_q;
  assign rsp_err2   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_lite2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_apb_master_lite2
//  Brief    : Self-checking bench for apb_master_lite2 (timeout limit 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_lite2;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          p_reset2;
  logic          cmd_valid2, cmd_ready2, cmd_write2;
  logic [AW-1:0] cmd_addr2;
  logic [DW-1:0] cmd_wdata2;
  logic          rsp_valid2, rsp_err2;
  logic [DW-1:0] rsp_rdata2;
  logic          psel2, penable2, pwrite2;
  logic [AW-1:0] paddr2;
  logic [DW-1:0] pwdata2, prdata2;
  logic          pready2, pslverr2;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  apb_master_lite2 #(
    .ADDR_WIDTH2(AW), .DATA_WIDTH2(DW), .TIMEOUT_CYCLES2(TO)
  ) dut (
    .pclk2(clk), .p_reset2(p_reset2),
    .cmd_valid2(cmd_valid2), .cmd_ready2(cmd_ready2), .cmd_write2(cmd_write2),
    .cmd_addr2(cmd_addr2), .cmd_wdata2(cmd_wdata2),
    .rsp_valid2(rsp_valid2), .rsp_rdata2(rsp_rdata2), .rsp_err2(rsp_err2),
    .psel2(psel2), .penable2(penable2), .pwrite2(pwrite2),
    .paddr2(paddr2), .pwdata2(pwdata2), .prdata2(prdata2),
    .pready2(pready2), .pslverr2(pslverr2)
  );

  // One transfer, checked cycle by cycle. Entered and left at a falling edge.
  task automatic run_xfer(input string nm, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int waits,
                          input logic [DW-1:0] rd, input bit serr, input bit tmo);
    rsp_t e;
    rsp_t exp;
    int   ncyc;
    n_checks++;
    if (cmd_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL %s.ready_idle got %0b want 1", nm, cmd_ready2);
    end
    cmd_valid2 = 1'b1; cmd_write2 = wr; cmd_addr2 = addr; cmd_wdata2 = wd;
    // Slave strobes outside ACCESS must be ignored.
    pready2 = 1'b1; pslverr2 = 1'b1; prdata2 = '1;
    @(negedge clk);  // SETUP cycle
    cmd_valid2 = 1'b0; cmd_write2 = !wr; cmd_addr2 = ~addr; cmd_wdata2 = ~wd;
    n_checks++;
    if ({psel2, penable2, cmd_ready2} !== 3'b100) begin
      n_fail++; $display("FAIL %s.setup psel/penable/ready got %b want 100", nm, {psel2, penable2, cmd_ready2});
    end
    n_checks++;
    if (paddr2 !== addr || pwrite2 !== wr || pwdata2 !== wd) begin
      n_fail++; $display("FAIL %s.setup_bus got a=%h w=%0b d=%h want a=%h w=%0b d=%h", nm, paddr2, pwrite2, pwdata2, addr, wr, wd);
    end
    e.rdata = (wr || tmo) ? '0 : rd;
    e.err   = serr || tmo;
    exp_q.push_back(e);
    ncyc = tmo ? TO : waits + 1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);  // ACCESS cycle k
      n_checks++;
      if ({psel2, penable2, rsp_valid2, cmd_ready2} !== 4'b1100) begin
        n_fail++; $display("FAIL %s.access%0d psel/pen/rsp/ready got %b want 1100", nm, k, {psel2, penable2, rsp_valid2, cmd_ready2});
      end
      n_checks++;
      if (paddr2 !== addr || pwrite2 !== wr || pwdata2 !== wd) begin
        n_fail++; $display("FAIL %s.access%0d_bus got a=%h w=%0b d=%h want a=%h w=%0b d=%h", nm, k, paddr2, pwrite2, pwdata2, addr, wr, wd);
      end
      pready2  = !tmo && (k == waits);
      pslverr2 = serr;
      prdata2  = rd;
    end
    @(negedge clk);  // response cycle
    pready2 = 1'b0; pslverr2 = 1'b0;
    n_checks++;
    if (rsp_valid2 !== 1'b1) begin
      n_fail++; $display("FAIL %s.rsp_valid got %0b want 1", nm, rsp_valid2);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s.scoreboard got empty queue want 1 entry", nm);
    end else begin
      exp = exp_q.pop_front();
      if (rsp_rdata2 !== exp.rdata || rsp_err2 !== exp.err) begin
        n_fail++; $display("FAIL %s.rsp got d=%h e=%0b want d=%h e=%0b", nm, rsp_rdata2, rsp_err2, exp.rdata, exp.err);
      end
    end
    n_checks++;
    if ({psel2, penable2, cmd_ready2} !== 3'b001) begin
      n_fail++; $display("FAIL %s.rsp_cycle psel/pen/ready got %b want 001", nm, {psel2, penable2, cmd_ready2});
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid2 !== 1'b0 || rsp_rdata2 !== e.rdata || rsp_err2 !== e.err) begin
      n_fail++; $display("FAIL %s.after_rsp got v=%0b d=%h e=%0b want v=0 d=%h e=%0b", nm, rsp_valid2, rsp_rdata2, rsp_err2, e.rdata, e.err);
    end
  endtask

  task automatic test_reset();
    p_reset2 = 1'b1;
    cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = '0; cmd_wdata2 = '0;
    prdata2 = '0; pready2 = 1'b0; pslverr2 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({psel2, penable2, pwrite2, rsp_valid2, rsp_err2, cmd_ready2} !== 6'b000001 ||
        paddr2 !== '0 || pwdata2 !== '0 || rsp_rdata2 !== '0) begin
      n_fail++; $display("FAIL reset.outputs got ctl=%b a=%h d=%h r=%h want ctl=000001 all zero", {psel2, penable2, pwrite2, rsp_valid2, rsp_err2, cmd_ready2}, paddr2, pwdata2, rsp_rdata2);
    end
    p_reset2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready2 !== 1'b1 || psel2 !== 1'b0) begin
      n_fail++; $display("FAIL reset.released got ready=%0b psel=%0b want 1 0", cmd_ready2, psel2);
    end
  endtask

  task automatic test_write();
    run_xfer("write", 1'b1, 6'h04, 32'h0000_00FF, 0, 32'h7777_7777, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    run_xfer("read", 1'b0, 6'h08, 32'h0, 0, 32'h0000_A5A5, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_xfer("wait3", 1'b0, 6'h18, 32'h0, 3, 32'h0000_1234, 1'b0, 1'b0);
  endtask

  task automatic test_slverr();
    run_xfer("slverr_wr", 1'b1, 6'h0C, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1'b0);
    run_xfer("clean_rd", 1'b0, 6'h10, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 1'b0, 6'h20, 32'h0, 0, 32'hDEAD_DEAD, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cmd_valid2 = 1'b1; cmd_write2 = 1'b1; cmd_addr2 = 6'h2C; cmd_wdata2 = 32'h1357_9BDF;
    pready2 = 1'b0; pslverr2 = 1'b1;
    @(negedge clk);  // SETUP
    cmd_valid2 = 1'b0;
    @(negedge clk);  // ACCESS
    n_checks++;
    if ({psel2, penable2, pwrite2} !== 3'b111) begin
      n_fail++; $display("FAIL rst_mid.in_access got %b want 111", {psel2, penable2, pwrite2});
    end
    #2 p_reset2 = 1'b1;
    #1;
    n_checks++;
    if ({psel2, penable2, pwrite2, rsp_valid2, rsp_err2, cmd_ready2} !== 6'b000001 ||
        paddr2 !== '0 || pwdata2 !== '0 || rsp_rdata2 !== '0) begin
      n_fail++; $display("FAIL rst_mid.async got ctl=%b a=%h d=%h r=%h want ctl=000001 all zero", {psel2, penable2, pwrite2, rsp_valid2, rsp_err2, cmd_ready2}, paddr2, pwdata2, rsp_rdata2);
    end
    pready2 = 1'b1;
    @(negedge clk);
    p_reset2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid2 !== 1'b0 || psel2 !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid.no_rsp%0d got v=%0b psel=%0b want 0 0", k, rsp_valid2, psel2);
      end
    end
    pready2 = 1'b0; pslverr2 = 1'b0;
  endtask

  // Three commands with cmd_valid2 held; slave always ready.
  task automatic test_back_to_back();
    int   idx = 0, nrsp = 0, cyc = 0, last_acc = -1;
    bit   adv = 1'b0;
    rsp_t e;
    rsp_t exp;
    cmd_valid2 = 1'b1; cmd_write2 = 1'b0; cmd_addr2 = 6'h30; cmd_wdata2 = 32'h0;
    pready2 = 1'b1;
    while (nrsp < 3 && cyc < 40) begin
      if (rsp_valid2) begin
        nrsp++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b.scoreboard rsp%0d got empty queue want entry", nrsp);
        end else begin
          exp = exp_q.pop_front();
          if (rsp_rdata2 !== exp.rdata || rsp_err2 !== exp.err) begin
            n_fail++; $display("FAIL b2b.rsp%0d got d=%h e=%0b want d=%h e=%0b", nrsp, rsp_rdata2, rsp_err2, exp.rdata, exp.err);
          end
        end
      end
      if (cmd_valid2 && cmd_ready2) begin
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 3) begin
            n_fail++; $display("FAIL b2b.spacing cmd%0d got %0d cycles want 3", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        e.rdata  = (idx == 1) ? '0 : (32'hB0B0_0000 + DW'(idx));
        e.err    = (idx == 1);
        exp_q.push_back(e);
        prdata2  = 32'hB0B0_0000 + DW'(idx);
        pslverr2 = (idx == 1);
        adv      = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) begin
          cmd_write2 = (idx == 1);
          cmd_addr2  = 6'h30 + AW'(idx * 4);
          cmd_wdata2 = 32'hC0DE_0000 + DW'(idx);
        end else begin
          cmd_valid2 = 1'b0;
        end
      end
    end
    n_checks++;
    if (nrsp != 3 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b.count got %0d responses (%0d pending) want 3 (0)", nrsp, exp_q.size());
    end
    pready2 = 1'b0; pslverr2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t want bench completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
